// File: rtl/hw_int_pkg.sv
// Shared definitions for the CP0 hardware interrupt controller: FSM encoding,
// MMIO register addresses and the priority helper.
package hw_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } hw_int_state_e;

    localparam logic [3:0] ADDR_ENABLE   = 4'd0;
    localparam logic [3:0] ADDR_MODE     = 4'd1;
    localparam logic [3:0] ADDR_PEND     = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_CNT_BASE = 4'd8;

    localparam logic [2:0] CUR_ID_NONE = 3'd7;

    // Highest set bit wins; an empty vector maps to CUR_ID_NONE.
    function automatic logic [2:0] hi_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = CUR_ID_NONE;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hw_int_ctrl_irq_sync_edge.sv
// Per-source synchroniser for an asynchronous interrupt line, plus the
// previous-value flop used to detect a rising edge.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], irq};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;

endmodule

// File: rtl/hw_int_ctrl.sv
// Interrupt controller feeding CP0 HWInt: per-source edge/level pending, enable
// mask, take/ERET tracking and an MMIO register file. HW_INT_CNT_EN adds take counters.
module hw_int_ctrl
    import hw_int_pkg::*;
#(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] dev_irq,
    input  logic             int_taken,
    input  logic             eret,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic [N_SRC-1:0] HWInt,
    output logic [2:0]       cur_id
);

    logic [N_SRC-1:0] sync;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] pend_edge_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] hw_int_d;
    logic [2:0]       cur_id_d;
    logic [2:0]       sel;
    hw_int_state_e    state_q;
    hw_int_state_e    state_d;
    logic             cfg_wdata_unused;

    assign cfg_wdata_unused = ^cfg_wdata[31:N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .reset(reset),
            .irq  (dev_irq[i]),
            .sync (sync[i]),
            .rise (rise[i])
        );
    end

    assign pend_clr = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
    // Edge bits are sticky flops; level bits follow the synchronised line.
    assign pend     = (pend_edge_q & mode_q) | (sync & ~mode_q);
    assign act      = pend & enable_q;
    // HWInt is the registered act CP0 saw when it took the interrupt.
    assign sel      = (HWInt != '0) ? hi_index(8'(HWInt)) : hi_index(8'(act));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pend_edge_q <= '0;
        end else begin
            if (cfg_we && cfg_addr == ADDR_ENABLE) enable_q <= cfg_wdata[N_SRC-1:0];
            if (cfg_we && cfg_addr == ADDR_MODE)   mode_q   <= cfg_wdata[N_SRC-1:0];
            // A new edge in the same cycle as a clear keeps the bit set.
            pend_edge_q <= ((pend_edge_q & ~pend_clr) | rise) & mode_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            HWInt   <= '0;
            cur_id  <= CUR_ID_NONE;
        end else begin
            state_q <= state_d;
            HWInt   <= hw_int_d;
            cur_id  <= cur_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hw_int_d = HWInt;
        cur_id_d = cur_id;
        case (state_q)
            IDLE: begin
                hw_int_d = '0;
                cur_id_d = CUR_ID_NONE;
                if (act != '0) state_d = REQ;
            end
            REQ: begin
                if (int_taken) begin
                    state_d  = SERVICE;
                    cur_id_d = sel;
                    hw_int_d = '0;
                end else if (act == '0) begin
                    state_d  = IDLE;
                    hw_int_d = '0;
                end else begin
                    hw_int_d = act;
                end
            end
            SERVICE: begin
                hw_int_d = '0;
                if (eret) begin
                    state_d  = IDLE;
                    cur_id_d = CUR_ID_NONE;
                end
            end
            default: begin
                state_d  = IDLE;
                hw_int_d = '0;
                cur_id_d = CUR_ID_NONE;
            end
        endcase
    end

`ifdef HW_INT_CNT_EN
    logic [15:0] cnt_q [N_SRC];
    logic        take;

    assign take = (state_q == REQ) && int_taken;

    // A clearing write in the same cycle as a take leaves the counter at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cfg_we && cfg_addr == ADDR_CNT_BASE + 4'(i)) cnt_q[i] <= '0;
                else if (take && cur_id_d == 3'(i))             cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE: cfg_rdata = 32'(enable_q);
            ADDR_MODE:   cfg_rdata = 32'(mode_q);
            ADDR_PEND:   cfg_rdata = 32'(pend);
            ADDR_STATUS: cfg_rdata = {27'b0, state_q, cur_id};
            default: begin
`ifdef HW_INT_CNT_EN
                for (int i = 0; i < N_SRC; i++) begin
                    if (cfg_addr == ADDR_CNT_BASE + 4'(i)) cfg_rdata = {16'b0, cnt_q[i]};
                end
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_hw_int_ctrl.sv
// Self-checking bench for hw_int_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the interrupt rules.
module tb_hw_int_ctrl;

    localparam int N  = 6;
    localparam int SS = 2;
`ifdef HW_INT_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  dev_irq;
    logic        int_taken;
    logic        eret;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [5:0]  HWInt;
    logic [2:0]  cur_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hw_int_ctrl #(.N_SRC(N), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset    (reset),
        .dev_irq  (dev_irq),
        .int_taken(int_taken),
        .eret     (eret),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .HWInt    (HWInt),
        .cur_id   (cur_id)
    );

    // ---------------- reference model ----------------
    logic [5:0] m_hist [$];   // dev_irq samples, newest first
    logic [5:0] m_en, m_mode, m_pend_edge, m_hwint;
    int         m_phase;      // 0 idle, 1 requesting, 2 servicing
    int         m_cur;
    int         m_cnt [6];

    function automatic int highest(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) if (v[i]) return i;
        return 7;
    endfunction

    function automatic logic [5:0] m_pend();
        logic [5:0] p;
        for (int i = 0; i < 6; i++)
            p[i] = m_mode[i] ? m_pend_edge[i] : m_hist[SS-1][i];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return 32'(m_en);
            4'd1: return 32'(m_mode);
            4'd2: return 32'(m_pend());
            4'd3: return {27'b0, 2'(m_phase), 3'(m_cur)};
            default: begin
                if (CNT_ON == 1 && a >= 4'd8 && a < 4'd14) return 32'(m_cnt[int'(a) - 8]);
                return 32'd0;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i <= SS; i++) m_hist.push_back(6'd0);
        m_en = 0; m_mode = 0; m_pend_edge = 0; m_hwint = 0;
        m_phase = 0; m_cur = 7;
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    endtask

    // Applies one clock edge using the inputs the DUT sees at that edge.
    task automatic model_step();
        logic [5:0] sync, prev, rise, act, clr;
        int sel;
        sync = m_hist[SS-1];
        prev = m_hist[SS];
        rise = sync & ~prev;
        act  = m_pend() & m_en;
        clr  = (cfg_we && cfg_addr == 4'd2) ? cfg_wdata[5:0] : 6'd0;
        case (m_phase)
            0: begin
                m_hwint = 0; m_cur = 7;
                if (act != 0) m_phase = 1;
            end
            1: begin
                if (int_taken) begin
                    sel = (m_hwint != 0) ? highest(m_hwint) : highest(act);
                    m_cur = sel; m_hwint = 0; m_phase = 2;
                    if (sel < 6) m_cnt[sel] = (m_cnt[sel] + 1) % 65536;
                end else if (act == 0) begin
                    m_phase = 0; m_hwint = 0;
                end else begin
                    m_hwint = act;
                end
            end
            default: begin
                m_hwint = 0;
                if (eret) begin m_phase = 0; m_cur = 7; end
            end
        endcase
        if (cfg_we && cfg_addr >= 4'd8 && cfg_addr < 4'd14) m_cnt[int'(cfg_addr) - 8] = 0;
        for (int i = 0; i < 6; i++)
            m_pend_edge[i] = m_mode[i] & ((m_pend_edge[i] & ~clr[i]) | rise[i]);
        if (cfg_we && cfg_addr == 4'd0) m_en   = cfg_wdata[5:0];
        if (cfg_we && cfg_addr == 4'd1) m_mode = cfg_wdata[5:0];
        m_hist.push_front(dev_irq);
        void'(m_hist.pop_back());
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check_eq(tag, cfg_rdata, exp);
    endtask

    task automatic check_outputs();
        logic [3:0] a;
        check_eq("hwint", 32'(HWInt), 32'(m_hwint));
        check_eq("cur_id", 32'(cur_id), 32'(m_cur));
        rd_chk("status", 4'd3, m_read(4'd3));
        a = 4'($urandom_range(15, 0));
        rd_chk("rd_any", a, m_read(a));
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic [5:0] dev, input logic tk, input logic er,
                         input logic we, input logic [3:0] a, input logic [31:0] wd);
        dev_irq = dev; int_taken = tk; eret = er;
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cfg_we = 1'b0; int_taken = 1'b0; eret = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(dev_irq, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cycle(dev_irq, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic take();
        cycle(dev_irq, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wait_hwint(input int budget);
        for (int i = 0; i < budget && HWInt == 6'd0; i++) idle(1);
        check_eq("wait_hwint", 32'(HWInt != 6'd0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; dev_irq = 0; int_taken = 0; eret = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_eq("rst_hwint", 32'(HWInt), 32'd0);
        check_eq("rst_cur_id", 32'(cur_id), 32'd7);
        rd_chk("rst_enable", 4'd0, 32'd0);

        // Edge capture on source 2
        wr(4'd1, 32'h3F);
        wr(4'd0, 32'h3F);
        cycle(6'h04, 0, 0, 0, 0, 0);
        cycle(6'h00, 0, 0, 0, 0, 0);
        idle(1);
        rd_chk("edge_pend", 4'd2, 32'h04);
        idle(2);
        check_eq("edge_hwint", 32'(HWInt), 32'h04);
        take();
        check_eq("edge_cur_id", 32'(cur_id), 32'd2);
        check_eq("edge_hwint_taken", 32'(HWInt), 32'd0);
        cycle(dev_irq, 0, 1, 1, 4'd2, 32'h04);
        check_eq("edge_eret_cur_id", 32'(cur_id), 32'd7);

        // Priority between sources 1 and 4
        cycle(6'h12, 0, 0, 0, 0, 0);
        cycle(6'h00, 0, 0, 0, 0, 0);
        idle(3);
        check_eq("prio_hwint", 32'(HWInt), 32'h12);
        take();
        check_eq("prio_cur_id", 32'(cur_id), 32'd4);
        cycle(dev_irq, 0, 1, 1, 4'd2, 32'h10);
        idle(2);
        check_eq("prio_next_hwint", 32'(HWInt), 32'h02);
        take();
        check_eq("prio_next_cur_id", 32'(cur_id), 32'd1);
        cycle(dev_irq, 0, 1, 1, 4'd2, 32'h02);

        // Masking
        wr(4'd0, 32'h01);
        cycle(6'h08, 0, 0, 0, 0, 0);
        cycle(6'h00, 0, 0, 0, 0, 0);
        idle(1);
        rd_chk("mask_pend", 4'd2, 32'h08);
        idle(2);
        check_eq("mask_hwint_off", 32'(HWInt), 32'd0);
        wr(4'd0, 32'h08);
        idle(2);
        check_eq("mask_hwint_on", 32'(HWInt), 32'h08);
        take();
        check_eq("mask_cur_id", 32'(cur_id), 32'd3);
        cycle(dev_irq, 0, 1, 1, 4'd2, 32'h08);
        wr(4'd0, 32'h3F);

        // Set and clear on the same edge bit in the same cycle
        cycle(6'h01, 0, 0, 0, 0, 0);
        cycle(6'h00, 0, 0, 0, 0, 0);
        wr(4'd2, 32'h01);
        rd_chk("race_pend", 4'd2, 32'h01);
        wr(4'd2, 32'h01);
        rd_chk("race_cleared", 4'd2, 32'h00);

        // Level source 5
        wr(4'd1, 32'h1F);
        cycle(6'h20, 0, 0, 0, 0, 0);
        idle(1);
        rd_chk("level_pend", 4'd2, 32'h20);
        wr(4'd2, 32'h20);
        rd_chk("level_w1c_ignored", 4'd2, 32'h20);
        cycle(6'h00, 0, 0, 0, 0, 0);
        idle(1);
        rd_chk("level_drop", 4'd2, 32'h00);
        wr(4'd1, 32'h3F);
        idle(2);

        // Asynchronous reset in SERVICE
        cycle(6'h01, 0, 0, 0, 0, 0);
        cycle(6'h00, 0, 0, 0, 0, 0);
        idle(3);
        take();
        rd_chk("svc_status", 4'd3, {27'b0, 2'd2, 3'd0});
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_eq("arst_hwint", 32'(HWInt), 32'd0);
        check_eq("arst_cur_id", 32'(cur_id), 32'd7);
        rd_chk("arst_enable", 4'd0, 32'd0);
        rd_chk("arst_mode", 4'd1, 32'd0);
        rd_chk("arst_pend", 4'd2, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(6'h00, 0, 1, 0, 0, 0);
        rd_chk("arst_eret_ignored", 4'd3, {27'b0, 2'd0, 3'd7});

        // Take counters on level source 1
        wr(4'd0, 32'h02);
        cycle(6'h02, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            wait_hwint(8);
            take();
            check_eq("cnt_cur_id", 32'(cur_id), 32'd1);
            cycle(dev_irq, 0, 1, 0, 0, 0);
        end
        cycle(6'h00, 0, 0, 1, 4'd0, 32'h00);
        rd_chk("cnt_value", 4'd9, (CNT_ON == 1) ? 32'd3 : 32'd0);
        wr(4'd9, 32'h0);
        rd_chk("cnt_cleared", 4'd9, 32'd0);
        idle(3);

        // Randomized traffic against the model
        wr(4'd0, 32'h3F);
        for (int n = 0; n < 600; n++) begin
            logic [5:0]  dev;
            logic        tk, er, we;
            logic [3:0]  a;
            logic [31:0] d;
            dev = dev_irq;
            if ($urandom_range(2, 0) == 0) dev = dev ^ (6'd1 << $urandom_range(5, 0));
            tk = ($urandom_range(3, 0) == 0) && !(m_phase == 1 && m_hwint == 0);
            er = ($urandom_range(3, 0) == 0);
            we = ($urandom_range(5, 0) == 0);
            a  = 4'($urandom_range(15, 0));
            d  = $urandom;
            cycle(dev, tk, er, we, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
